// File: rtl/regfile_storage_pkg.sv
// regfile_pkg: shared widths and types for the register file storage and its read-mux banks.
package regfile_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int ZERO_REG   = 31;

    typedef logic [DATA_WIDTH-1:0]                reg_word_t;
    typedef reg_word_t                            word_t;
    typedef logic [ADDR_WIDTH-1:0]                addr_t;
    typedef logic [NUM_REGS-1:0]                  onehot_t;
    typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_array_t;

    // One-hot write enable; all-zero whenever we is low, regardless of addr.
    function automatic onehot_t decode(input logic we, input addr_t addr);
        return we ? onehot_t'(1) << addr : '0;
    endfunction
endpackage

// File: rtl/regfile_storage_if.sv
// regfile_storage_if: single write port of the register file.
interface regfile_storage_if;
    import regfile_pkg::*;
    logic  RegWrite;
    addr_t WriteRegister;
    word_t WriteData;
    modport master (output RegWrite, WriteRegister, WriteData);
    modport slave  (input  RegWrite, WriteRegister, WriteData);
endinterface

// File: rtl/regfile_storage_reg_en.sv
// reg_en: enabled flop bank with asynchronous active-low clear.
module reg_en
    import regfile_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/regfile_storage.sv
// regfile_storage: 32 x 64-bit architectural registers with one write port; XZR reads as zero.
module regfile_storage
    import regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_storage_if.slave        wr,
    output reg_array_t              regs,
    output onehot_t                 wr_hit
);
    onehot_t en;

    assign en = decode(wr.RegWrite, wr.WriteRegister);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_flop
            reg_en #(.W(DATA_WIDTH)) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en[g]),
                .d     (wr.WriteData),
                .q     (regs[g])
            );
        end
    end

    // Writes to XZR are discarded, so they never show up as a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_hit <= '0;
        else wr_hit <= en & ~(onehot_t'(1) << ZERO_REG);
    end
endmodule

// File: tb/tb_regfile_storage.sv
// tb_regfile_storage: table-driven write vectors with a scoreboard plus reset/same-cycle sequences.
module tb_regfile_storage;
    import regfile_pkg::*;

    typedef struct {
        logic    we;
        addr_t   addr;
        word_t   data;
        int      idx;
        word_t   val;
        onehot_t hit;
        string   name;
    } vec_t;

    typedef struct {
        string   name;
        int      idx;
        word_t   val;
        onehot_t hit;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    reg_array_t regs;
    onehot_t    wr_hit;

    regfile_storage_if wif ();

    regfile_storage dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (wif),
        .regs   (regs),
        .wr_hit (wr_hit)
    );

    always #5 clk = ~clk;

    word_t model [NUM_REGS];
    exp_t  sb [$];
    vec_t  vecs [$];
    int    passed = 0;
    int    total  = 0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic chk_all(input string name);
        int bad = -1;
        total++;
        for (int i = 0; i < NUM_REGS; i++)
            if (bad < 0 && regs[i] !== model[i]) bad = i;
        if (bad >= 0)
            $display("FAIL %s_all: regs[%0d] got %h expected %h", name, bad, regs[bad], model[bad]);
        else passed++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endtask

    task automatic drive(input logic we, input addr_t a, input word_t d,
                         input int idx, input word_t val, input onehot_t hit, input string name);
        wif.RegWrite      = we;
        wif.WriteRegister = a;
        wif.WriteData     = d;
        if (we === 1'b1 && int'(a) != ZERO_REG) model[a] = d;
        sb.push_back('{name, idx, val, hit});
    endtask

    task automatic edge_check();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk(e.name, regs[e.idx], e.val);
            chk({e.name, "_hit"}, word_t'(wr_hit), word_t'(e.hit));
            chk_all(e.name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        wif.RegWrite      = 1'b0;
        wif.WriteRegister = '0;
        wif.WriteData     = '0;
        clear_model();

        // Reset asserts before any clock edge: storage clears asynchronously.
        #2 rst_n = 1'b0;
        #1;
        chk_all("reset_async");
        chk("reset_async_hit", word_t'(wr_hit), '0);
        repeat (3) @(negedge clk);
        chk_all("reset_held");
        rst_n = 1'b1;

        for (int k = 0; k < ZERO_REG; k++)
            vecs.push_back('{1'b1, addr_t'(k), 64'hA5A5_0000_0000_0000 + word_t'(k), k,
                             64'hA5A5_0000_0000_0000 + word_t'(k), onehot_t'(1) << k,
                             $sformatf("seq_wr%0d", k)});
        vecs.push_back('{1'b0, addr_t'(7), 64'hFFFF_FFFF_FFFF_FFFF, 7,
                         64'hA5A5_0000_0000_0007, '0, "we_low"});
        vecs.push_back('{1'b0, 'x, 64'hFFFF_FFFF_FFFF_FFFF, 9,
                         64'hA5A5_0000_0000_0009, '0, "we_low_xaddr"});
        vecs.push_back('{1'b1, addr_t'(31), 64'hDEAD_BEEF_DEAD_BEEF, 31, '0, '0, "xzr_write"});
        vecs.push_back('{1'b1, addr_t'(30), 64'h0123_4567_89AB_CDEF, 30,
                         64'h0123_4567_89AB_CDEF, onehot_t'(1) << 30, "rewrite30"});

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].idx,
                  vecs[i].val, vecs[i].hit, vecs[i].name);
            edge_check();
        end

        // Same-cycle read of a register being written returns the old value.
        drive(1'b1, addr_t'(5), 64'h1234, 5, 64'h1234, onehot_t'(1) << 5, "wr5_a");
        #1 chk("wr5_pre", regs[5], 64'hA5A5_0000_0000_0005);
        edge_check();
        drive(1'b1, addr_t'(5), 64'h5678, 5, 64'h5678, onehot_t'(1) << 5, "wr5_b");
        #1 chk("wr5_b_pre", regs[5], 64'h1234);
        edge_check();

        // Reset mid-cycle wipes storage; the write on the coinciding edge is lost.
        drive(1'b1, addr_t'(3), 64'h42, 3, 64'h42, onehot_t'(1) << 3, "wr3_42");
        edge_check();
        wif.WriteData = 64'h77;
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        chk("midrst_reg3", regs[3], '0);
        chk_all("midrst");
        chk("midrst_hit", word_t'(wr_hit), '0);
        @(negedge clk);
        chk("midrst_lost", regs[3], '0);
        rst_n = 1'b1;
        drive(1'b1, addr_t'(3), 64'h99, 3, 64'h99, onehot_t'(1) << 3, "post_rst_wr3");
        #1 chk("post_rst_pre", regs[3], '0);
        edge_check();
        drive(1'b0, addr_t'(3), 64'h0, 3, 64'h99, '0, "idle_clear_hit");
        edge_check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
